// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and decoder-shared field positions for the pipeline sequencer
package pipe_ctrl_pkg;
   localparam int REG_AW = 4;
   localparam int RD_LSB = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;
   typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, BFLUSH = 2'd2, MWAIT = 2'd3} state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the ID sources and the EX load target
module hazard_detect #(
   parameter int REG_AW = 4
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              hazard
);
   assign hazard = ex_valid && ex_mem_read &&
                   ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC write enable and IF/ID, ID/EX, EX/MEM enable/flush sequencing.
// Optional HAZ_STATS_EN adds saturating stall/flush statistics counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
   parameter int LOAD_STALL_N = 1,
   parameter int FLUSH_N = 2
`ifdef HAZ_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_br_taken,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic [1:0]        state
`ifdef HAZ_STATS_EN
   , output logic [STAT_W-1:0] stall_cnt
   , output logic [STAT_W-1:0] flush_cnt
`endif
);
   localparam logic [1:0] FLUSH_INIT = FLUSH_N > 1 ? 2'(FLUSH_N - 2) : 2'd0;
   localparam logic [1:0] STALL_INIT = LOAD_STALL_N > 1 ? 2'(LOAD_STALL_N - 2) : 2'd0;
   state_e state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic hazard;
   hazard_detect #(.REG_AW(REG_AW)) u_hd (
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .hazard(hazard)
   );
   assign state = state_q;
   // Priority: reset, memory freeze, branch flush window, new branch, load-use stall, run
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pc_we = 1'b1;
      ifid_en = 1'b1;
      idex_en = 1'b1;
      exmem_en = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (rst) begin
         pc_we = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
         exmem_en = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d = RUN;
         cnt_d = 2'd0;
      end else if (mem_busy) begin
         pc_we = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
         exmem_en = 1'b0;
         state_d = state_q == RUN ? MWAIT : state_q;
      end else if (state_q == BFLUSH) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d = cnt_q == 2'd0 ? RUN : BFLUSH;
         cnt_d = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
      end else if (ex_br_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d = FLUSH_N == 1 ? RUN : BFLUSH;
         cnt_d = FLUSH_INIT;
      end else if (hazard || state_q == STALL) begin
         pc_we = 1'b0;
         ifid_en = 1'b0;
         idex_flush = 1'b1;
         if (state_q == STALL) begin
            state_d = cnt_q == 2'd0 ? RUN : STALL;
            cnt_d = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
         end else begin
            state_d = LOAD_STALL_N == 1 ? RUN : STALL;
            cnt_d = STALL_INIT;
         end
      end else begin
         state_d = RUN;
      end
   end
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
   end
`ifdef HAZ_STATS_EN
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic stall_ev, br_ev;
   // A stall bubble is the only case with idex_flush but not ifid_flush
   assign stall_ev = idex_flush && !ifid_flush;
   assign br_ev = !rst && !mem_busy && state_q != BFLUSH && ex_br_taken;
   always_comb begin
      stall_cnt_d = rst ? '0 : (stall_ev && !(&stall_cnt_q)) ? stall_cnt_q + STAT_W'(1) : stall_cnt_q;
      flush_cnt_d = rst ? '0 : (br_ev && !(&flush_cnt_q)) ? flush_cnt_q + STAT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge clk) begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif
endmodule
